// File: rtl/receiver_comp_pkg.sv
// Shared types for the receiver-compensation bank controller: FSM encoding,
// requester IDs and default widths.
package receiver_comp_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_CAL  = 1'b1;

endpackage

// File: rtl/receiver_comp_bank_ctrl_arb.sv
// rr_arbiter2: two-input round-robin grant, combinational grant with a
// registered priority pointer that moves to the other requester on a grant.
module rr_arbiter2
  import receiver_comp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i[0] && req_i[1]) begin
        gnt_o[ptr_q] = 1'b1;
        ptr_d        = ~ptr_q;
      end else if (req_i[REQ_HOST]) begin
        gnt_o[REQ_HOST] = 1'b1;
        ptr_d           = REQ_CAL;
      end else if (req_i[REQ_CAL]) begin
        gnt_o[REQ_CAL] = 1'b1;
        ptr_d          = REQ_HOST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= REQ_HOST;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/receiver_comp_bank_ctrl.sv
// Ping-pong coefficient bank controller: active-bank read indexing, shadow-bank
// write arbitration and frame-aligned swap. RECV_COMP_TUSER_SYNC_EN enables tuser resync.
//
// state   | meaning
// IDLE    | no swap outstanding, shadow writes granted
// PENDING | swap requested, waiting for a frame boundary, writes frozen
// COMMIT  | bank flipped this cycle, swap_done asserted, writes frozen
module receiver_comp_bank_ctrl
  import receiver_comp_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int DATA_CNT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tvalid_s,
  input  logic          tready_s,
  input  logic          tlast_s,
  input  logic          tuser_s,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_gnt,
  input  logic          cal_req,
  input  logic [AW-1:0] cal_addr,
  input  logic [DW-1:0] cal_data,
  output logic          cal_gnt,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_done,
  output logic          active_bank,
  output logic [AW:0]   mem_raddr,
  output logic          mem_we,
  output logic [AW:0]   mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [15:0]   frame_cnt
);

  state_e        state_q;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_frame_q, in_frame_d;
  logic          active_bank_q, swap_pending_q, swap_done_q;
  logic          mem_we_q;
  logic [AW:0]   mem_waddr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [15:0]   frame_cnt_q;
  logic          beat, boundary;
  logic [1:0]    req, gnt;

  always_comb begin
    beat       = tvalid_s & tready_s;
    idx_d      = idx_q;
    in_frame_d = in_frame_q;
    boundary   = (beat & tlast_s) | (~in_frame_q & ~beat);
    if (beat) begin
      in_frame_d = ~tlast_s;
      if (tlast_s || idx_q == AW'(DATA_CNT - 1)) idx_d = '0;
      else                                       idx_d = idx_q + 1'b1;
`ifdef RECV_COMP_TUSER_SYNC_EN
      // tuser marks sample 0, so the next read index is 1
      if (tuser_s && !tlast_s) idx_d = AW'(1);
      boundary = boundary | (tuser_s & in_frame_q);
`endif
    end
  end

`ifndef RECV_COMP_TUSER_SYNC_EN
  logic unused_tuser;
  assign unused_tuser = tuser_s;
`endif

  assign req = {cal_req, host_req};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == ST_IDLE),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      in_frame_q     <= 1'b0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= '0;
      mem_wdata_q    <= '0;
      frame_cnt_q    <= '0;
    end else begin
      idx_q       <= idx_d;
      in_frame_q  <= in_frame_d;
      swap_done_q <= 1'b0;
      if (beat && tlast_s) frame_cnt_q <= frame_cnt_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (swap_req) begin
            state_q        <= ST_PENDING;
            swap_pending_q <= 1'b1;
          end
        end
        ST_PENDING: begin
          // flip on the boundary edge so the first beat of the new frame reads the new bank
          if (boundary) begin
            state_q       <= ST_COMMIT;
            active_bank_q <= ~active_bank_q;
            swap_done_q   <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q        <= ST_IDLE;
          swap_pending_q <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          swap_pending_q <= 1'b0;
        end
      endcase

      mem_we_q <= |gnt;
      if (|gnt) begin
        mem_waddr_q <= {~active_bank_q, gnt[REQ_CAL] ? cal_addr : host_addr};
        mem_wdata_q <= gnt[REQ_CAL] ? cal_data : host_data;
      end
    end
  end

  assign host_gnt     = gnt[REQ_HOST];
  assign cal_gnt      = gnt[REQ_CAL];
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign active_bank  = active_bank_q;
  assign mem_raddr    = {active_bank_q, idx_q};
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_receiver_comp_bank_ctrl.sv
// Self-checking bench for receiver_comp_bank_ctrl: read indexing, arbitration,
// frame-aligned swap and reset behaviour, with scoreboard queues for reads and writes.
module tb_receiver_comp_bank_ctrl;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tvalid_s, tready_s, tlast_s, tuser_s;
  logic          host_req, cal_req, swap_req;
  logic [AW-1:0] host_addr, cal_addr;
  logic [DW-1:0] host_data, cal_data;
  logic          host_gnt, cal_gnt, swap_pending, swap_done, active_bank, mem_we;
  logic [AW:0]   mem_raddr, mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [15:0]   frame_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [AW:0] exp_rd_q[$];

  always #5 clk = ~clk;

  receiver_comp_bank_ctrl #(.DW(DW), .AW(AW), .DATA_CNT(1024)) dut (
    .clk(clk), .reset(reset),
    .tvalid_s(tvalid_s), .tready_s(tready_s), .tlast_s(tlast_s), .tuser_s(tuser_s),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_gnt(host_gnt),
    .cal_req(cal_req), .cal_addr(cal_addr), .cal_data(cal_data), .cal_gnt(cal_gnt),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .active_bank(active_bank), .mem_raddr(mem_raddr), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .frame_cnt(frame_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    tvalid_s = 0; tready_s = 0; tlast_s = 0; tuser_s = 0;
    host_req = 0; cal_req = 0; swap_req = 0;
    host_addr = '0; cal_addr = '0; host_data = '0; cal_data = '0;
  endtask

  // leaves the bench at posedge+1 with reset released
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    if ({mem_raddr, mem_we, swap_pending, swap_done, active_bank, host_gnt, cal_gnt} !== '0) begin
      $display("FAIL reset_outputs: got raddr=%h we=%b pend=%b done=%b bank=%b, required all 0",
               mem_raddr, mem_we, swap_pending, swap_done, active_bank);
      miscompares++;
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      $display("FAIL reset_frame_cnt: got %h required 0", frame_cnt); miscompares++;
    end
    vectors++;
    step();
    // go mid-frame and pending, then reset again
    for (int k = 0; k < 6; k++) begin
      tvalid_s = 1; tready_s = 1; swap_req = (k == 3);
      step();
    end
    swap_req = 0;
    @(negedge clk);
    if (swap_pending !== 1'b1) begin
      $display("FAIL reset_pre_pending: got %b required 1", swap_pending); miscompares++;
    end
    vectors++;
    do_reset();
    @(negedge clk);
    if (mem_raddr !== '0 || swap_pending !== 1'b0) begin
      $display("FAIL reset_midframe: got raddr=%h pend=%b required 0/0", mem_raddr, swap_pending);
      miscompares++;
    end
    vectors++;
    // idle stream after reset: a surviving pending swap would commit here
    repeat (3) step();
    @(negedge clk);
    if (active_bank !== 1'b0 || swap_pending !== 1'b0) begin
      $display("FAIL reset_drop_swap: got bank=%b pend=%b required 0/0", active_bank, swap_pending);
      miscompares++;
    end
    vectors++;
    step();
  endtask

  task automatic test_frame();
    logic [AW:0] e;
    do_reset();
    for (int k = 0; k < 1024; k++) begin
      if (k % 256 == 128) begin
        tvalid_s = 1; tready_s = 0; tlast_s = 0;
        @(negedge clk);
        if (mem_raddr !== (AW+1)'(k)) begin
          $display("FAIL frame_stall: got %h required %h", mem_raddr, (AW+1)'(k)); miscompares++;
        end
        vectors++;
        step();
      end
      tvalid_s = 1; tready_s = 1; tlast_s = (k == 1023);
      exp_rd_q.push_back((AW+1)'(k));
      @(negedge clk);
      e = exp_rd_q.pop_front();
      if (mem_raddr !== e) begin
        $display("FAIL frame_raddr: got %h required %h", mem_raddr, e); miscompares++;
      end
      vectors++;
      step();
    end
    idle_inputs();
    @(negedge clk);
    if (mem_raddr !== '0 || frame_cnt !== 16'd1) begin
      $display("FAIL frame_end: got raddr=%h frame_cnt=%0d required 0/1", mem_raddr, frame_cnt);
      miscompares++;
    end
    vectors++;
    step();
  endtask

  task automatic test_arbitration();
    int  h_n = 0, c_n = 0;
    logic exp_h, exp_c;
    wr_t w;
    do_reset();
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (exp_wr_q.size() > 0) begin
        w = exp_wr_q.pop_front();
        if (mem_we !== 1'b1 || mem_waddr !== w.addr || mem_wdata !== w.data) begin
          $display("FAIL arb_write: got we=%b addr=%h data=%h required 1/%h/%h",
                   mem_we, mem_waddr, mem_wdata, w.addr, w.data);
          miscompares++;
        end
      end else if (mem_we !== 1'b0) begin
        $display("FAIL arb_no_write: got we=%b required 0", mem_we); miscompares++;
      end
      vectors++;
      host_req  = (cyc < 4);
      cal_req   = (cyc < 7);
      host_addr = AW'(10'h010 + h_n); host_data = DW'(16'hA000 + h_n);
      cal_addr  = AW'(10'h200 + c_n); cal_data  = DW'(16'hC000 + c_n);
      exp_h = (cyc < 4) && (cyc % 2 == 0);
      exp_c = (cyc < 4) ? (cyc % 2 == 1) : (cyc < 7);
      #1;
      if (host_gnt !== exp_h || cal_gnt !== exp_c) begin
        $display("FAIL arb_gnt cyc%0d: got host=%b cal=%b required %b/%b",
                 cyc, host_gnt, cal_gnt, exp_h, exp_c);
        miscompares++;
      end
      vectors++;
      if (exp_h) begin
        exp_wr_q.push_back({1'b1, host_addr, host_data}); h_n++;
      end
      if (exp_c) begin
        exp_wr_q.push_back({1'b1, cal_addr, cal_data}); c_n++;
      end
      step();
    end
    idle_inputs();
    if (exp_wr_q.size() != 0) begin
      $display("FAIL arb_queue: %0d writes never observed, required 0", exp_wr_q.size());
      miscompares++;
      exp_wr_q.delete();
    end
    vectors++;
  endtask

  task automatic test_swap_midframe();
    logic [AW:0] e_rd;
    logic        e_pend, e_done, e_hg;
    do_reset();
    for (int k = 0; k < 1027; k++) begin
      tvalid_s  = 1; tready_s = 1; tlast_s = (k == 1023);
      swap_req  = (k == 500) || (k == 600) || (k == 1024);
      host_req  = (k >= 501) && (k <= 1025);
      host_addr = AW'(10'h055); host_data = 16'h5A5A;
      e_rd   = (k < 1024) ? (AW+1)'(k) : {1'b1, AW'(k - 1024)};
      e_pend = (k >= 501) && (k <= 1024);
      e_done = (k == 1024);
      e_hg   = (k == 1025);
      @(negedge clk);
      if (mem_raddr !== e_rd || swap_pending !== e_pend || swap_done !== e_done || host_gnt !== e_hg) begin
        $display("FAIL swap_mid k=%0d: got raddr=%h pend=%b done=%b hgnt=%b required %h/%b/%b/%b",
                 k, mem_raddr, swap_pending, swap_done, host_gnt, e_rd, e_pend, e_done, e_hg);
        miscompares++;
      end
      vectors++;
      if (k == 1026) begin
        if (mem_we !== 1'b1 || mem_waddr !== {1'b0, AW'(10'h055)} || mem_wdata !== 16'h5A5A) begin
          $display("FAIL swap_mid_write: got we=%b addr=%h data=%h required 1/055/5a5a",
                   mem_we, mem_waddr, mem_wdata);
          miscompares++;
        end
        vectors++;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_swap_idle();
    do_reset();
    swap_req = 1;
    @(negedge clk);
    if (swap_pending !== 1'b0) begin
      $display("FAIL swap_idle_t0: got pend=%b required 0", swap_pending); miscompares++;
    end
    vectors++;
    step();
    swap_req = 0;
    @(negedge clk);
    if (swap_pending !== 1'b1 || swap_done !== 1'b0 || active_bank !== 1'b0) begin
      $display("FAIL swap_idle_t1: got pend=%b done=%b bank=%b required 1/0/0",
               swap_pending, swap_done, active_bank);
      miscompares++;
    end
    vectors++;
    step();
    swap_req = 1;  // lands in COMMIT and must be dropped
    @(negedge clk);
    if (swap_done !== 1'b1 || active_bank !== 1'b1 || mem_raddr !== 11'h400) begin
      $display("FAIL swap_idle_t2: got done=%b bank=%b raddr=%h required 1/1/400",
               swap_done, active_bank, mem_raddr);
      miscompares++;
    end
    vectors++;
    step();
    swap_req = 0;
    repeat (2) step();
    @(negedge clk);
    if (swap_done !== 1'b0 || swap_pending !== 1'b0 || active_bank !== 1'b1) begin
      $display("FAIL swap_idle_t3: got done=%b pend=%b bank=%b required 0/0/1",
               swap_done, swap_pending, active_bank);
      miscompares++;
    end
    vectors++;
    step();
  endtask

  task automatic test_wrap();
    logic [AW:0] e;
    do_reset();
    for (int k = 0; k < 1030; k++) begin
      tvalid_s = 1; tready_s = 1; tlast_s = 0;
      exp_rd_q.push_back((AW+1)'(k % 1024));
      @(negedge clk);
      e = exp_rd_q.pop_front();
      if (mem_raddr !== e) begin
        $display("FAIL wrap_raddr k=%0d: got %h required %h", k, mem_raddr, e); miscompares++;
      end
      vectors++;
      step();
    end
    idle_inputs();
    @(negedge clk);
    if (mem_raddr !== 11'h006 || frame_cnt !== 16'd0) begin
      $display("FAIL wrap_end: got raddr=%h frame_cnt=%0d required 006/0", mem_raddr, frame_cnt);
      miscompares++;
    end
    vectors++;
    step();
  endtask

`ifdef RECV_COMP_TUSER_SYNC_EN
  task automatic test_tuser_sync();
    do_reset();
    for (int k = 0; k < 38; k++) begin
      tvalid_s = 1; tready_s = 1; tuser_s = (k == 37); swap_req = (k == 10);
      step();
    end
    idle_inputs();
    tvalid_s = 1; tready_s = 1;
    @(negedge clk);
    if (mem_raddr !== 11'h401 || swap_done !== 1'b1) begin
      $display("FAIL tuser_sync: got raddr=%h done=%b required 401/1", mem_raddr, swap_done);
      miscompares++;
    end
    vectors++;
    step();
    idle_inputs();
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_frame();
    test_arbitration();
    test_swap_midframe();
    test_swap_idle();
    test_wrap();
`ifdef RECV_COMP_TUSER_SYNC_EN
    test_tuser_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/receiver_comp_bank_ctrl.md
Name: receiver_comp_bank_ctrl

Overview:
Sequences the receiver-compensation coefficient memory as two ping-pong banks: the active bank is read by the sample index of the streaming datapath, and the shadow bank accepts coefficient writes.
Arbitrates shadow-bank writes between the host (AHB-side register writer) and the calibration engine.
Commits a bank swap only at a frame boundary, so a frame is never compensated with mixed coefficients.
Sits beside the compensation datapath and drives its coefficient RAM address and write ports.

Parameters:
DW, 16, coefficient width
AW, 10, coefficient index width (table depth 2**AW)
DATA_CNT, 1024, samples per frame; index wraps at DATA_CNT-1

Ports:
clk  in  1  clock
reset  in  1  reset
tvalid_s  in  1  monitored stream valid
tready_s  in  1  monitored stream ready
tlast_s  in  1  monitored end of frame
tuser_s  in  1  monitored start-of-frame marker
host_req  in  1  host write request
host_addr  in  AW  host coefficient index
host_data  in  DW  host coefficient value
host_gnt  out  1  host write accepted this cycle
cal_req  in  1  calibration write request
cal_addr  in  AW  calibration coefficient index
cal_data  in  DW  calibration coefficient value
cal_gnt  out  1  calibration write accepted this cycle
swap_req  in  1  single-cycle pulse requesting a bank swap
swap_pending  out  1  swap requested, not yet committed
swap_done  out  1  single-cycle pulse on commit
active_bank  out  1  bank currently read by the datapath
mem_raddr  out  AW+1  {active_bank, idx} read address
mem_we  out  1  shadow-bank write strobe
mem_waddr  out  AW+1  {~active_bank, addr}
mem_wdata  out  DW  write data
frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high (`reset`).
- Reset values: all outputs 0, idx=0, in_frame=0, FSM=IDLE, round-robin pointer=host.
- Beat = tvalid_s && tready_s.
- idx:
  - On a beat, idx goes to 0 if tlast_s or idx==DATA_CNT-1, else idx+1.
  - mem_raddr is driven directly from registers, with no combinational path from the inputs.
- in_frame: set on a beat without tlast_s; cleared on a beat with tlast_s.
- frame_cnt: +1 on each tlast beat.
- Boundary: true in a cycle with a tlast beat, or when in_frame==0 and there is no beat.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE -> PENDING on swap_req.
  - PENDING -> COMMIT on boundary.
  - COMMIT lasts one cycle: flips active_bank, pulses swap_done, then -> IDLE.
  - swap_pending=1 in PENDING and COMMIT.
  - swap_req in PENDING or COMMIT is ignored (no queuing).
  - swap_req and boundary in the same IDLE cycle -> PENDING only; the commit waits for the next boundary.
- Write arbitration:
  - Grants are issued only in IDLE; PENDING and COMMIT freeze the shadow bank (both gnt=0).
  - gnt is combinational from req, state and pointer, at most one per cycle.
  - Round-robin: on a grant, the pointer moves to the other requester.
  - A single requester is granted back-to-back every cycle.
  - The requester holds req/addr/data until gnt.
- Write latency: mem_we, mem_waddr and mem_wdata are registered one cycle after gnt.
  - mem_waddr bank bit = ~active_bank as sampled at grant.
  - A write granted in the last IDLE cycle still lands in the old shadow bank.
- Reset mid-frame or mid-PENDING: everything returns to reset values and the pending swap is dropped.

Optional Feature:
Macro RECV_COMP_TUSER_SYNC_EN.
- Defined: a beat with tuser_s=1 forces idx to 1 (the sample is index 0) and sets in_frame, resynchronising after a lost tlast. A tuser beat while in_frame=1 also counts as a boundary for a PENDING swap, applied before the sample is read: COMMIT happens that cycle.
- Undefined: tuser_s is ignored; only tlast and wrap drive idx.

Decomposition:
- Shared package (receiver_comp_pkg): FSM state encoding (IDLE=2'd0, PENDING=2'd1, COMMIT=2'd2), requester IDs (REQ_HOST=0, REQ_CAL=1), default AW/DW.
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with pointer register, reused elsewhere.

Test Plan:
- Reset then 1024 beats with tlast on the last -> mem_raddr runs 0x000..0x3FF, returns to 0x000; frame_cnt=1.
- host_req and cal_req held together for 4 cycles in IDLE -> gnt alternates host, cal, host, cal; mem_we sequence follows one cycle later with bank bit 1.
- swap_req at idx=500 mid-frame -> swap_pending=1, no gnt during PENDING; swap_done on the tlast beat+1 cycle; active_bank=1; mem_raddr next frame starts 0x400.
- swap_req while stream idle (in_frame=0) -> COMMIT the following cycle; swap_done 2 cycles after swap_req.
- 1030 beats with no tlast -> idx wraps to 0 after 1023, continues 0..5; frame_cnt unchanged.
- With RECV_COMP_TUSER_SYNC_EN: tuser beat at idx=37 -> next read idx=1; with a PENDING swap, swap_done fires that cycle.
